// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Read-side controller of the asynchronous FIFO, in the read
//               clock domain. Converts the synchronized Gray write pointer to
//               binary, issues RAM reads, and feeds a 2-entry output buffer
//               that covers the 1-cycle RAM read latency behind a
//               valid/ready interface. Returns a registered Gray read pointer
//               for the write-domain synchronizer and reports empty,
//               almost-empty and fill level.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : ADDR_WIDTH    RAM address width (depth = 2**ADDR_WIDTH)
//               DATA_WIDTH    word width
//               AEMPTY_THRESH almost_empty asserts when rd_level <= this
// Macro       : FIFO_RD_AEMPTY_EN - when defined, almost_empty is computed;
//               when undefined, almost_empty is tied low and AEMPTY_THRESH
//               has no effect.
// Ports       : clk_trg          read-domain clock
//               rst_trg          synchronous active-high reset
//               wr_ptr_gray_sync write pointer (Gray), synchronized to clk_trg
//               rd_ptr_gray      registered Gray read pointer
//               ram_rd_en        RAM read strobe
//               ram_rd_addr      RAM read address
//               ram_rd_data      RAM read data (valid cycle after ram_rd_en)
//               m_valid/m_ready  output handshake
//               m_data           output word (buffer head)
//               empty            no unread words left in RAM
//               almost_empty     rd_level <= AEMPTY_THRESH
//               rd_level         RAM unread + in flight + buffered words
// ============================================================================
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk_trg,
   input  logic                  rst_trg,
   input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
   output logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level
);

   localparam int c_PTR_W = ADDR_WIDTH + 1;

   // State encoding equals the number of buffered words.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } occ_state_t;

   occ_state_t              r_state;
   occ_state_t              w_state_nxt;
   logic [c_PTR_W-1:0]      r_rd_bin;
   logic [c_PTR_W-1:0]      w_rd_bin_nxt;
   logic [c_PTR_W-1:0]      r_rd_ptr_gray;
   logic                    r_inflight;
   logic [DATA_WIDTH-1:0]   r_buf0;        // head entry
   logic [DATA_WIDTH-1:0]   r_buf1;        // second entry
   logic [DATA_WIDTH-1:0]   w_buf0_nxt;
   logic [DATA_WIDTH-1:0]   w_buf1_nxt;
   logic [c_PTR_W-1:0]      w_wr_bin;
   logic [c_PTR_W-1:0]      w_ram_words;
   logic [1:0]              w_occ;
   logic [2:0]              w_busy;
   logic                    w_arrive;
   logic                    w_pop;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i < c_PTR_W; i++) begin : g_gray2bin
      assign w_wr_bin[i] = ^wr_ptr_gray_sync[c_PTR_W-1:i];
   end

   assign w_ram_words = w_wr_bin - r_rd_bin;
   assign w_occ       = r_state;
   assign w_busy      = {1'b0, w_occ} + {2'b00, r_inflight};

   // A read is issued only if a buffer slot is guaranteed free from registered
   // state alone, so m_ready never reaches the RAM strobe combinationally.
   // The cost is that a word in flight plus a word held blocks the next read
   // even when that held word is being popped.
   assign ram_rd_en    = !rst_trg && (w_ram_words != '0) && (w_busy < 3'd2);
   assign ram_rd_addr  = r_rd_bin[ADDR_WIDTH-1:0];
   assign w_rd_bin_nxt = ram_rd_en ? (r_rd_bin + c_PTR_W'(1)) : r_rd_bin;

   assign rd_ptr_gray = r_rd_ptr_gray;
   assign empty       = (r_rd_ptr_gray == wr_ptr_gray_sync);
   assign rd_level    = w_ram_words + c_PTR_W'(r_inflight) + c_PTR_W'(w_occ);

`ifdef FIFO_RD_AEMPTY_EN
   assign almost_empty = (rd_level <= c_PTR_W'(AEMPTY_THRESH));
`else
   assign almost_empty = 1'b0;
`endif

   assign m_valid  = (r_state != S_EMPTY);
   assign m_data   = r_buf0;
   assign w_arrive = r_inflight;
   assign w_pop    = m_valid && m_ready;

   always_ff @(posedge clk_trg) begin
      if (rst_trg) begin
         r_state       <= S_EMPTY;
         r_rd_bin      <= '0;
         r_rd_ptr_gray <= '0;
         r_inflight    <= 1'b0;
         r_buf0        <= '0;
         r_buf1        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_rd_bin      <= w_rd_bin_nxt;
         r_rd_ptr_gray <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
         r_inflight    <= ram_rd_en;
         r_buf0        <= w_buf0_nxt;
         r_buf1        <= w_buf1_nxt;
      end
   end

   // Output buffer: arrivals go to the tail, pops take the head. Arrival in
   // S_TWO cannot happen because no read is issued while two slots are busy.
   always_comb begin
      w_state_nxt = r_state;
      w_buf0_nxt  = r_buf0;
      w_buf1_nxt  = r_buf1;
      case (r_state)
         S_EMPTY: begin
            if (w_arrive) begin
               w_buf0_nxt  = ram_rd_data;
               w_state_nxt = S_ONE;
            end
         end
         S_ONE: begin
            case ({w_arrive, w_pop})
               2'b10: begin
                  w_buf1_nxt  = ram_rd_data;
                  w_state_nxt = S_TWO;
               end
               2'b01: begin
                  w_state_nxt = S_EMPTY;
               end
               2'b11: begin
                  // Head leaves and the new word takes its place.
                  w_buf0_nxt  = ram_rd_data;
               end
               default: begin
               end
            endcase
         end
         S_TWO: begin
            if (w_pop) begin
               w_buf0_nxt  = r_buf1;
               w_state_nxt = S_ONE;
            end
         end
         default: begin
            w_state_nxt = S_EMPTY;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Self-checking bench for fifo_rd_ctrl (ADDR_WIDTH = 3). A
//               vector table covers reset, a single word and a short
//               backpressured pair; hand-written sequences cover streaming,
//               longer backpressure, pointer wrap and almost-empty.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

   localparam int AW = 3;
   localparam int DW = 32;
   localparam int PW = AW + 1;
   localparam int TH = 2;

   logic          clk_trg = 1'b0;
   logic          rst_trg;
   logic [PW-1:0] wr_ptr_gray_sync;
   logic [PW-1:0] rd_ptr_gray;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          empty;
   logic          almost_empty;
   logic [PW-1:0] rd_level;

   fifo_rd_ctrl #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .AEMPTY_THRESH(TH)
   ) dut (
      .clk_trg         (clk_trg),
      .rst_trg         (rst_trg),
      .wr_ptr_gray_sync(wr_ptr_gray_sync),
      .rd_ptr_gray     (rd_ptr_gray),
      .ram_rd_en       (ram_rd_en),
      .ram_rd_addr     (ram_rd_addr),
      .ram_rd_data     (ram_rd_data),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .m_data          (m_data),
      .empty           (empty),
      .almost_empty    (almost_empty),
      .rd_level        (rd_level)
   );

   always #5 clk_trg = ~clk_trg;

   // RAM model: 1-cycle read latency.
   logic [DW-1:0] mem [8];
   always @(posedge clk_trg) begin
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   int            wr_cnt;
   logic [PW-1:0] wr_b;
   assign wr_b             = wr_cnt[PW-1:0];
   assign wr_ptr_gray_sync = wr_b ^ (wr_b >> 1);

   int total = 0;
   int bad   = 0;

   // Reference model state
   int rd_issued, consumed, occ_m, infl_m;
   int n_reads_obs;
   logic [PW-1:0] prev_gray;
   bit saw_wrap;
   bit ae_prev;
   int rise_lvl;

   function automatic logic [DW-1:0] word(input int n);
      return 32'hC0DE_0000 + 32'(n);
   endfunction

   function automatic logic [PW-1:0] gray_of(input int n);
      logic [PW-1:0] b;
      b = PW'(n);
      return b ^ (b >> 1);
   endfunction

   function automatic logic ae_exp(input int lvl);
`ifdef FIFO_RD_AEMPTY_EN
      return (lvl <= TH);
`else
      return (lvl < 0);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_trg);
      #1;
   endtask

   // Writer never lets more than 8 words be outstanding.
   task automatic write_to(input int target);
      while (wr_cnt < target && (wr_cnt - consumed) < 8) begin
         mem[wr_cnt % 8] = word(wr_cnt);
         wr_cnt++;
      end
   endtask

   task automatic cycle(input logic rdy, input int target, input string tag);
      logic exp_en;
      bit   pop;
      m_ready = rdy;
      write_to(target);
      #1;
      exp_en = (wr_cnt != rd_issued) && ((occ_m + infl_m) < 2);
      chk({tag, "_rd_en"}, 32'(ram_rd_en), 32'(exp_en));
      if (exp_en) chk({tag, "_addr"}, 32'(ram_rd_addr), 32'(rd_issued % 8));
      chk({tag, "_gray"}, 32'(rd_ptr_gray), 32'(gray_of(rd_issued)));
      chk({tag, "_valid"}, 32'(m_valid), 32'(occ_m != 0));
      if (occ_m != 0) chk({tag, "_data"}, m_data, word(consumed));
      chk({tag, "_empty"}, 32'(empty), 32'(wr_cnt == rd_issued));
      chk({tag, "_level"}, 32'(rd_level), 32'(wr_cnt - consumed));
      chk({tag, "_aempty"}, 32'(almost_empty), 32'(ae_exp(wr_cnt - consumed)));
      if (ram_rd_en === 1'b1) n_reads_obs++;
      if (prev_gray == 4'b1000 && rd_ptr_gray == 4'b0000) saw_wrap = 1'b1;
      prev_gray = rd_ptr_gray;
      if (almost_empty === 1'b1 && !ae_prev && rise_lvl < 0) rise_lvl = int'(rd_level);
      ae_prev = (almost_empty === 1'b1);
      pop = (occ_m != 0) && rdy;
      occ_m = occ_m + infl_m - (pop ? 1 : 0);
      infl_m = exp_en ? 1 : 0;
      if (exp_en) rd_issued++;
      if (pop) consumed++;
      tick();
   endtask

   typedef struct {
      logic        rst;
      int          wr;
      logic        rdy;
      logic        en;
      logic [2:0]  addr;
      logic [3:0]  gray;
      logic        valid;
      logic        chkd;
      logic [31:0] data;
      logic        empty;
      logic [3:0]  level;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] held;
      bit have;

      vecs[0]  = '{1'b1, 0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 32'h0,         1'b1, 4'd0};
      vecs[1]  = '{1'b0, 0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 32'h0,         1'b1, 4'd0};
      vecs[2]  = '{1'b0, 1, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0, 1'b1, 32'h0,         1'b0, 4'd1};
      vecs[3]  = '{1'b0, 1, 1'b1, 1'b0, 3'd1, 4'd1, 1'b0, 1'b1, 32'h0,         1'b1, 4'd1};
      vecs[4]  = '{1'b0, 1, 1'b1, 1'b0, 3'd1, 4'd1, 1'b1, 1'b1, 32'hC0DE0000, 1'b1, 4'd1};
      vecs[5]  = '{1'b0, 1, 1'b1, 1'b0, 3'd1, 4'd1, 1'b0, 1'b0, 32'h0,         1'b1, 4'd0};
      vecs[6]  = '{1'b0, 3, 1'b0, 1'b1, 3'd1, 4'd1, 1'b0, 1'b0, 32'h0,         1'b0, 4'd2};
      vecs[7]  = '{1'b0, 3, 1'b0, 1'b1, 3'd2, 4'd3, 1'b0, 1'b0, 32'h0,         1'b0, 4'd2};
      vecs[8]  = '{1'b0, 3, 1'b0, 1'b0, 3'd3, 4'd2, 1'b1, 1'b1, 32'hC0DE0001, 1'b1, 4'd2};
      vecs[9]  = '{1'b0, 3, 1'b1, 1'b0, 3'd3, 4'd2, 1'b1, 1'b1, 32'hC0DE0001, 1'b1, 4'd2};
      vecs[10] = '{1'b0, 3, 1'b1, 1'b0, 3'd3, 4'd2, 1'b1, 1'b1, 32'hC0DE0002, 1'b1, 4'd1};
      vecs[11] = '{1'b0, 3, 1'b1, 1'b0, 3'd3, 4'd2, 1'b0, 1'b0, 32'h0,         1'b1, 4'd0};

      rst_trg   = 1'b1;
      m_ready   = 1'b1;
      wr_cnt    = 0;
      consumed  = 0;
      rd_issued = 0;
      occ_m     = 0;
      infl_m    = 0;
      n_reads_obs = 0;
      prev_gray = '0;
      saw_wrap  = 1'b0;
      ae_prev   = 1'b1;
      rise_lvl  = -1;
      repeat (2) @(posedge clk_trg);
      #1;

      // Reset (third reset cycle), single word, and a two-word pair with
      // backpressure.
      for (int i = 0; i < 12; i++) begin
         rst_trg = vecs[i].rst;
         m_ready = vecs[i].rdy;
         while (wr_cnt < vecs[i].wr) begin
            mem[wr_cnt % 8] = word(wr_cnt);
            wr_cnt++;
         end
         #1;
         chk($sformatf("vec%0d_rd_en", i), 32'(ram_rd_en), 32'(vecs[i].en));
         chk($sformatf("vec%0d_addr", i), 32'(ram_rd_addr), 32'(vecs[i].addr));
         chk($sformatf("vec%0d_gray", i), 32'(rd_ptr_gray), 32'(vecs[i].gray));
         chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].valid));
         if (vecs[i].chkd) chk($sformatf("vec%0d_data", i), m_data, vecs[i].data);
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
         chk($sformatf("vec%0d_level", i), 32'(rd_level), 32'(vecs[i].level));
         chk($sformatf("vec%0d_aempty", i), 32'(almost_empty), 32'(ae_exp(int'(vecs[i].level))));
         tick();
      end
      consumed  = 3;
      rd_issued = 3;
      prev_gray = rd_ptr_gray;

      // Streaming: 8 words at once, consumer always ready.
      for (int i = 0; i < 40 && consumed < 11; i++) cycle(1'b1, 11, "stream");
      chk("stream_done", 32'(consumed), 32'd11);

      // Backpressure: 8 words, consumer stalled 10 cycles.
      n_reads_obs = 0;
      have = 1'b0;
      held = '0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 19, "bp");
         if (m_valid) begin
            if (!have) begin
               held = m_data;
               have = 1'b1;
            end else begin
               chk("bp_hold", m_data, held);
            end
         end
      end
      chk("bp_reads", 32'(n_reads_obs), 32'd2);
      chk("bp_level", 32'(rd_level), 32'd8);
      chk("bp_head", m_data, word(11));
      for (int i = 0; i < 40 && consumed < 19; i++) cycle(1'b1, 19, "bp_drain");
      chk("bp_done", 32'(consumed), 32'd19);

      // Wrap: 40 more words through the 8-deep RAM.
      saw_wrap = 1'b0;
      for (int i = 0; i < 200 && consumed < 59; i++) cycle(1'b1, 59, "wrap");
      chk("wrap_done", 32'(consumed), 32'd59);
      chk("wrap_seen", 32'(saw_wrap), 32'd1);

      // Almost-empty: fill to 5, then drain.
      ae_prev  = 1'b1;
      rise_lvl = -1;
      repeat (3) cycle(1'b0, 64, "ae_fill");
      for (int i = 0; i < 30 && consumed < 64; i++) cycle(1'b1, 64, "ae_drain");
      chk("ae_done", 32'(consumed), 32'd64);
`ifdef FIFO_RD_AEMPTY_EN
      chk("ae_rise_level", 32'(rise_lvl), 32'd2);
`else
      chk("ae_never", 32'(rise_lvl), 32'hFFFF_FFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
